// File: rtl/ct_lsu_wmb_cmplt_queue_if.sv
// Completion-request handshake between the WMB, the completion queue and the
// store WB stage, plus the flush, stall and empty sideband signals.
interface ct_lsu_wmb_cmplt_queue_if;
    logic       rtu_yy_xx_flush;
    logic       wmb_cq_enq_vld;
    logic [6:0] wmb_cq_enq_iid;
    logic       wmb_cq_enq_inst_flush;
    logic       wmb_cq_enq_spec_fail;
    logic       wmb_cq_enq_bkpta_data;
    logic       wmb_cq_enq_bkptb_data;
    logic       cq_wmb_enq_grnt;
    logic       st_wb_wmb_cmplt_grnt;
    logic       wmb_st_wb_cmplt_req;
    logic [6:0] wmb_st_wb_iid;
    logic       wmb_st_wb_inst_flush;
    logic       wmb_st_wb_spec_fail;
    logic       wmb_st_wb_bkpta_data;
    logic       wmb_st_wb_bkptb_data;
    logic       cq_st_da_stall_req;
    logic       cq_empty;

    // Queue side.
    modport slave (
        input  rtu_yy_xx_flush, wmb_cq_enq_vld, wmb_cq_enq_iid, wmb_cq_enq_inst_flush,
               wmb_cq_enq_spec_fail, wmb_cq_enq_bkpta_data, wmb_cq_enq_bkptb_data,
               st_wb_wmb_cmplt_grnt,
        output cq_wmb_enq_grnt, wmb_st_wb_cmplt_req, wmb_st_wb_iid, wmb_st_wb_inst_flush,
               wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data,
               cq_st_da_stall_req, cq_empty
    );

    // WMB / RTU / WB side.
    modport master (
        output rtu_yy_xx_flush, wmb_cq_enq_vld, wmb_cq_enq_iid, wmb_cq_enq_inst_flush,
               wmb_cq_enq_spec_fail, wmb_cq_enq_bkpta_data, wmb_cq_enq_bkptb_data,
               st_wb_wmb_cmplt_grnt,
        input  cq_wmb_enq_grnt, wmb_st_wb_cmplt_req, wmb_st_wb_iid, wmb_st_wb_inst_flush,
               wmb_st_wb_spec_fail, wmb_st_wb_bkpta_data, wmb_st_wb_bkptb_data,
               cq_st_da_stall_req, cq_empty
    );
endinterface

// File: rtl/ct_lsu_wmb_cmplt_queue.sv
// In-order completion-request queue between the WMB and the store WB stage.
// The head is offered to WB; a starvation counter raises a DA stall request
// when the fixed-priority DA pipe keeps the head ungranted for too long.
module ct_lsu_wmb_cmplt_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned PTR_W         = 2,
    parameter int unsigned STARVE_THRESH = 8
) (
    input logic                     ctrl_st_clk,
    input logic                     cpurst_b,
    ct_lsu_wmb_cmplt_queue_if.slave cq_if
);

    localparam int unsigned EntW = 11;
    localparam logic [PTR_W:0] DepthCnt = (PTR_W + 1)'(DEPTH);
    localparam logic [7:0] Thresh = 8'(STARVE_THRESH);

    logic [EntW-1:0]  entry_q [DEPTH];
    logic [EntW-1:0]  entry_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [7:0]       starve_cnt_q, starve_cnt_d;

    logic            head_vld;
    logic            deq;
    logic            enq;
    logic [EntW-1:0] head;
    logic [EntW-1:0] enq_ent;

    // Head presentation, handshake decode and anti-starvation stall.
    always_comb begin
        head_vld = (count_q != '0);
        head     = head_vld ? entry_q[rd_ptr_q] : '0;
        deq      = cq_if.st_wb_wmb_cmplt_grnt && head_vld;
        // A pop in the same cycle frees a slot, so a full queue may still accept.
        enq      = cq_if.wmb_cq_enq_vld && !cq_if.rtu_yy_xx_flush &&
                   ((count_q < DepthCnt) || deq);
        enq_ent  = {cq_if.wmb_cq_enq_iid, cq_if.wmb_cq_enq_inst_flush,
                    cq_if.wmb_cq_enq_spec_fail, cq_if.wmb_cq_enq_bkpta_data,
                    cq_if.wmb_cq_enq_bkptb_data};

        cq_if.cq_wmb_enq_grnt      = enq;
        cq_if.wmb_st_wb_cmplt_req  = head_vld;
        cq_if.wmb_st_wb_iid        = head[10:4];
        cq_if.wmb_st_wb_inst_flush = head[3];
        cq_if.wmb_st_wb_spec_fail  = head[2];
        cq_if.wmb_st_wb_bkpta_data = head[1];
        cq_if.wmb_st_wb_bkptb_data = head[0];
        cq_if.cq_empty             = !head_vld;
        // Drops in the grant cycle so DA is not stalled once WB has taken the head.
        cq_if.cq_st_da_stall_req   = head_vld && (starve_cnt_q >= Thresh) &&
                                     !cq_if.rtu_yy_xx_flush && !cq_if.st_wb_wmb_cmplt_grnt;
    end

    // Next-state for storage, pointers, occupancy and starvation counter.
    always_comb begin
        entry_d      = entry_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;

        if (cq_if.rtu_yy_xx_flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            starve_cnt_d = '0;
        end else begin
            if (enq) begin
                entry_d[wr_ptr_q] = enq_ent;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (deq || !head_vld) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != 8'hff) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge ctrl_st_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            entry_q      <= entry_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_ct_lsu_wmb_cmplt_queue.sv
// Self-checking bench for the WMB completion queue: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_ct_lsu_wmb_cmplt_queue;

    localparam int Depth  = 4;
    localparam int Thresh = 8;

    logic clk;
    logic rst_b;
    int   n_cmp;
    int   n_err;

    // Reference model state.
    logic [10:0] mq[$];
    int          starve;

    ct_lsu_wmb_cmplt_queue_if cq_if ();

    ct_lsu_wmb_cmplt_queue #(
        .DEPTH         (Depth),
        .PTR_W         (2),
        .STARVE_THRESH (Thresh)
    ) u_dut (
        .ctrl_st_clk (clk),
        .cpurst_b    (rst_b),
        .cq_if       (cq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk(input logic [6:0] iid, input logic [3:0] flags);
        return {iid, flags};
    endfunction

    function automatic logic [10:0] head_obs();
        return {cq_if.wmb_st_wb_iid, cq_if.wmb_st_wb_inst_flush, cq_if.wmb_st_wb_spec_fail,
                cq_if.wmb_st_wb_bkpta_data, cq_if.wmb_st_wb_bkptb_data};
    endfunction

    // Apply one cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic vld, input logic [10:0] ent, input logic gnt,
                         input logic fl);
        cq_if.wmb_cq_enq_vld        = vld;
        cq_if.wmb_cq_enq_iid        = ent[10:4];
        cq_if.wmb_cq_enq_inst_flush = ent[3];
        cq_if.wmb_cq_enq_spec_fail  = ent[2];
        cq_if.wmb_cq_enq_bkpta_data = ent[1];
        cq_if.wmb_cq_enq_bkptb_data = ent[0];
        cq_if.st_wb_wmb_cmplt_grnt  = gnt;
        cq_if.rtu_yy_xx_flush       = fl;
        #1;
    endtask

    // Compare all outputs against the model, then clock both.
    task automatic tick();
        logic        vld, gnt, fl, er, edq, eeg, est;
        logic [10:0] eh, ent;
        vld = cq_if.wmb_cq_enq_vld;
        gnt = cq_if.st_wb_wmb_cmplt_grnt;
        fl  = cq_if.rtu_yy_xx_flush;
        ent = mk(cq_if.wmb_cq_enq_iid, {cq_if.wmb_cq_enq_inst_flush, cq_if.wmb_cq_enq_spec_fail,
                                        cq_if.wmb_cq_enq_bkpta_data, cq_if.wmb_cq_enq_bkptb_data});
        er  = (mq.size() != 0);
        eh  = er ? mq[0] : 11'h0;
        edq = gnt && er;
        eeg = vld && !fl && ((mq.size() < Depth) || edq);
        est = er && (starve >= Thresh) && !fl && !gnt;
        check("req", 32'(cq_if.wmb_st_wb_cmplt_req), 32'(er));
        check("head", 32'(head_obs()), 32'(eh));
        check("enq_grnt", 32'(cq_if.cq_wmb_enq_grnt), 32'(eeg));
        check("stall_req", 32'(cq_if.cq_st_da_stall_req), 32'(est));
        check("empty", 32'(cq_if.cq_empty), 32'(!er));
        @(posedge clk);
        if (fl) begin
            mq.delete();
            starve = 0;
        end else begin
            if (edq) void'(mq.pop_front());
            if (eeg) mq.push_back(ent);
            if (edq || !er) starve = 0;
            else if (starve < 255) starve++;
        end
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 11'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        starve = 0;
        rst_b  = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(cq_if.wmb_st_wb_cmplt_req), 32'd0);
        check("rst_empty", 32'(cq_if.cq_empty), 32'd1);
        check("rst_stall", 32'(cq_if.cq_st_da_stall_req), 32'd0);
        check("rst_grnt", 32'(cq_if.cq_wmb_enq_grnt), 32'd0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Single request, one-cycle latency, granted right away.
        drive(1'b1, mk(7'h05, 4'b0100), 1'b0, 1'b0);
        check("t1_no_bypass", 32'(cq_if.wmb_st_wb_cmplt_req), 32'd0);
        tick();
        drive(1'b0, 11'h0, 1'b1, 1'b0);
        check("t1_iid", 32'(cq_if.wmb_st_wb_iid), 32'h05);
        check("t1_spec_fail", 32'(cq_if.wmb_st_wb_spec_fail), 32'd1);
        tick();
        idle();
        check("t1_empty", 32'(cq_if.cq_empty), 32'd1);
        tick();

        // Fill, full rejection, pop+push when full, in-order drain across wrap.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(7'(8'h10 + i), 4'(i)), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, mk(7'h7f, 4'h0), 1'b0, 1'b0);
        check("t2_full_grnt", 32'(cq_if.cq_wmb_enq_grnt), 32'd0);
        tick();
        drive(1'b1, mk(7'h14, 4'b1001), 1'b1, 1'b0);
        check("t2_full_pop_grnt", 32'(cq_if.cq_wmb_enq_grnt), 32'd1);
        check("t2_head0", 32'(cq_if.wmb_st_wb_iid), 32'h10);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 11'h0, 1'b1, 1'b0);
            check("t2_order", 32'(cq_if.wmb_st_wb_iid), 32'(8'h11 + i));
            tick();
        end

        // Starvation: stall after Thresh ungranted cycles, drops with the grant.
        drive(1'b1, mk(7'h30, 4'h0), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(7'h31, 4'h0), 1'b0, 1'b0);
        tick();
        for (int i = 1; i < Thresh; i++) begin
            idle();
            check("t3_no_stall", 32'(cq_if.cq_st_da_stall_req), 32'd0);
            tick();
        end
        idle();
        check("t3_stall", 32'(cq_if.cq_st_da_stall_req), 32'd1);
        tick();
        drive(1'b0, 11'h0, 1'b1, 1'b0);
        check("t3_stall_drop", 32'(cq_if.cq_st_da_stall_req), 32'd0);
        tick();
        idle();
        check("t3_next_head", 32'(cq_if.wmb_st_wb_iid), 32'h31);
        tick();
        drive(1'b0, 11'h0, 1'b1, 1'b0);
        tick();

        // Flush with three queued entries and a simultaneous enqueue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(7'(8'h1a + i), 4'h0), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, mk(7'h20, 4'h0), 1'b0, 1'b1);
        check("t4_flush_grnt", 32'(cq_if.cq_wmb_enq_grnt), 32'd0);
        tick();
        idle();
        check("t4_req", 32'(cq_if.wmb_st_wb_cmplt_req), 32'd0);
        check("t4_empty", 32'(cq_if.cq_empty), 32'd1);
        tick();
        drive(1'b1, mk(7'h21, 4'b0010), 1'b0, 1'b0);
        tick();
        drive(1'b0, 11'h0, 1'b1, 1'b0);
        check("t4_head", 32'(cq_if.wmb_st_wb_iid), 32'h21);
        tick();

        // Grants while empty are ignored.
        repeat (3) begin
            drive(1'b0, 11'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, mk(7'h33, 4'h0), 1'b0, 1'b0);
        tick();
        drive(1'b0, 11'h0, 1'b1, 1'b0);
        check("t5_head", 32'(cq_if.wmb_st_wb_iid), 32'h33);
        tick();

        // Asynchronous reset with two entries queued.
        drive(1'b1, mk(7'h40, 4'h0), 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(7'h41, 4'h0), 1'b0, 1'b0);
        tick();
        idle();
        rst_b = 1'b0;
        #1;
        mq.delete();
        starve = 0;
        check("t6_req", 32'(cq_if.wmb_st_wb_cmplt_req), 32'd0);
        check("t6_stall", 32'(cq_if.cq_st_da_stall_req), 32'd0);
        check("t6_empty", 32'(cq_if.cq_empty), 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        tick();
        idle();
        check("t6_post_empty", 32'(cq_if.cq_empty), 32'd1);
        tick();

        // Randomized traffic in phases of varying grant pressure.
        for (int ph = 0; ph < 20; ph++) begin
            int gp;
            gp = $urandom_range(0, 9);
            for (int c = 0; c < 100; c++) begin
                drive(1'($urandom_range(0, 9) < 6), 11'($urandom),
                      1'($urandom_range(0, 9) < gp), 1'($urandom_range(0, 99) < 3));
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
